p19_tinyqv_uart_tx: RTL and testbench

UART transmit peripheral on the TinyQV non-memory data bus (addresses with `data_addr[27:25] != 0`). It accepts CPU byte writes into a small FIFO and serialises them as 8N1 frames on a single TX pin. It also exposes status and baud-divisor registers, and drives a level interrupt that feeds one of the CPU's status-type `interrupt_req` bits.

---
 rtl/p19_tinyqv_periph_pkg.sv | 22 ++
 rtl/p19_tinyqv_uart_tx_if.sv | 23 ++
 rtl/p19_tinyqv_sync_fifo.sv | 49 ++++
 rtl/p19_tinyqv_uart_tx.sv | 166 ++++++++++++++++
 tb/tb_p19_tinyqv_uart_tx.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/p19_tinyqv_periph_pkg.sv
// Shared definitions for the TinyQV UART transmit peripheral:
// register offsets, STATUS bit layout and serialiser states.
package p19_tinyqv_periph_pkg;

    localparam logic [3:0] REG_TXDATA  = 4'h0;
    localparam logic [3:0] REG_STATUS  = 4'h4;
    localparam logic [3:0] REG_DIVISOR = 4'h8;

    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_EMPTY_BIT = 2;
    localparam int STATUS_LEVEL_LSB = 4;
    localparam int STATUS_LEVEL_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

endpackage

// File: rtl/p19_tinyqv_uart_tx_if.sv
// TinyQV non-memory data-bus slice seen by one peripheral; the bus
// wrapper has already decoded the peripheral select.
interface p19_tinyqv_uart_tx_if;

    logic        sel;
    logic [3:0]  addr;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        data_ready;

    modport master (
        output sel, addr, data_write_n, data_read_n, data_in,
        input  data_out, data_ready
    );

    modport slave (
        input  sel, addr, data_write_n, data_read_n, data_in,
        output data_out, data_ready
    );

endinterface

// File: rtl/p19_tinyqv_sync_fifo.sv
// Single-clock circular FIFO with extra-MSB pointers so full and empty
// are distinguishable without a separate counter.
module p19_tinyqv_sync_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_full,
    output logic              o_empty,
    output logic [AW:0]       o_level
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic              w_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_level = r_wptr - r_rptr;
    assign o_rdata = r_mem[r_rptr[AW-1:0]];
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push)
                r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop)
                r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // A push into a full FIFO only happens alongside a pop; the slot being
    // overwritten is read out on the same edge.
    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/p19_tinyqv_uart_tx.sv
// TinyQV UART transmitter: TXDATA/STATUS/DIVISOR registers, TX FIFO and
// an 8N1 serialiser with back-to-back frames and an empty interrupt.
module p19_tinyqv_uart_tx
    import p19_tinyqv_periph_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd555
) (
    input  logic                 clk,
    input  logic                 rst,
    p19_tinyqv_uart_tx_if.slave  bus,
    output logic                 uart_txd,
    output logic                 tx_empty_irq
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    function automatic logic [15:0] sat_div(input logic [15:0] v);
        return (v < 16'd2) ? 16'd2 : v;
    endfunction

    tx_state_e          r_state;
    tx_state_e          w_state_nxt;
    logic [15:0]        r_div;
    logic [15:0]        r_baud;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic               r_irq;

    logic [3:0]         w_off;
    logic               w_wr;
    logic               w_rd;
    logic               w_txdata_wr;
    logic               w_div_wr;
    logic               w_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_bit_end;
    logic [LVL_W-1:0]   w_level;
    logic [4:0]         w_level5;
    logic [7:0]         w_fifo_dout;
    logic [31:0]        w_rdata;
    logic               w_unused;

    assign w_off       = {bus.addr[3:2], 2'b00};
    assign w_wr        = bus.sel & (bus.data_write_n != 2'b11);
    assign w_rd        = bus.sel & (bus.data_read_n != 2'b11) & ~w_wr;
    assign w_txdata_wr = w_wr & (w_off == REG_TXDATA);
    assign w_div_wr    = w_wr & (w_off == REG_DIVISOR);
    assign w_bit_end   = (r_baud == 16'd0);

    // Only a TXDATA write against a full FIFO can stall, and a pop on the
    // same edge frees the slot it needs.
    assign w_ready        = (w_wr | w_rd) & ~(w_txdata_wr & w_full & ~w_pop);
    assign w_push         = w_txdata_wr & w_ready;
    assign bus.data_ready = w_ready;

    p19_tinyqv_sync_fifo #(
        .DATA_W (8),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (bus.data_in[7:0]),
        .o_rdata (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_end)
                    w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (w_bit_end && (r_bit == 3'd7))
                    w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_START;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A new divisor is only picked up when the baud counter reloads, so
    // the bit in flight keeps its length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_div   <= DIV_RESET;
            r_irq   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop || ((r_state != ST_IDLE) && w_bit_end))
                r_baud <= r_div;
            else if (r_state != ST_IDLE)
                r_baud <= r_baud - 16'd1;
            if (r_state == ST_START)
                r_bit <= '0;
            else if ((r_state == ST_DATA) && w_bit_end)
                r_bit <= r_bit + 3'd1;
            if (w_div_wr)
                r_div <= sat_div(bus.data_in[15:0]);
            if (w_push)
                r_irq <= 1'b0;
            else if ((r_state == ST_STOP) && w_bit_end && w_empty)
                r_irq <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_pop)
            r_shift <= w_fifo_dout;
        else if ((r_state == ST_DATA) && w_bit_end)
            r_shift <= {1'b0, r_shift[7:1]};
    end

    assign uart_txd     = (r_state == ST_START) ? 1'b0 :
                          (r_state == ST_DATA)  ? r_shift[0] : 1'b1;
    assign tx_empty_irq = r_irq;

    assign w_level5 = 5'(w_level);

    always_comb begin
        w_rdata = '0;
        case (w_off)
            REG_STATUS: begin
                w_rdata[STATUS_BUSY_BIT]  = (r_state != ST_IDLE);
                w_rdata[STATUS_FULL_BIT]  = w_full;
                w_rdata[STATUS_EMPTY_BIT] = w_empty;
                w_rdata[STATUS_LEVEL_LSB +: STATUS_LEVEL_W] = w_level5[3:0];
            end
            REG_DIVISOR: w_rdata[15:0] = r_div;
            default: ;
        endcase
    end

    assign bus.data_out = w_rd ? w_rdata : 32'd0;

    assign w_unused = ^{bus.data_in[31:16], bus.addr[1:0], w_level5[4]};

endmodule

// File: tb/tb_p19_tinyqv_uart_tx.sv
// Bench for p19_tinyqv_uart_tx: a frame-level model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_p19_tinyqv_uart_tx;

    localparam int          DEPTH   = 4;
    localparam logic [15:0] DIV_RST = 16'd555;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic uart_txd;
    logic tx_empty_irq;

    p19_tinyqv_uart_tx_if bus ();

    p19_tinyqv_uart_tx #(
        .FIFO_DEPTH (DEPTH),
        .DIV_RESET  (DIV_RST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .uart_txd     (uart_txd),
        .tx_empty_irq (tx_empty_irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- frame-level model ----------------
    byte unsigned m_q[$];
    bit           m_active = 1'b0;
    bit [9:0]     m_frame  = '1;
    int           m_pos    = 0;
    int           m_left   = 0;
    bit           m_irq    = 1'b1;
    logic [15:0]  m_div    = DIV_RST;

    function automatic bit m_req_wr();
        return bus.sel && (bus.data_write_n != 2'b11);
    endfunction

    function automatic bit m_req_rd();
        return bus.sel && (bus.data_read_n != 2'b11) && !m_req_wr();
    endfunction

    function automatic logic [3:0] m_off();
        return {bus.addr[3:2], 2'b00};
    endfunction

    function automatic bit m_pop_now();
        return (m_q.size() > 0) && (!m_active || (m_pos == 9 && m_left == 1));
    endfunction

    function automatic bit m_ready();
        if (!(m_req_wr() || m_req_rd()))
            return 1'b0;
        if (m_req_wr() && m_off() == 4'h0 && m_q.size() == DEPTH && !m_pop_now())
            return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_rdata();
        logic [31:0] v;
        v = 32'd0;
        case (m_off())
            4'h4: v = {24'd0, 4'(m_q.size()), 1'b0, (m_q.size() == 0),
                       (m_q.size() == DEPTH), m_active};
            4'h8: v = {16'd0, m_div};
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    task automatic m_start();
        byte unsigned b;
        b        = m_q.pop_front();
        m_frame  = {1'b1, b, 1'b0};
        m_pos    = 0;
        m_left   = int'(m_div) + 1;
        m_active = 1'b1;
    endtask

    always @(posedge clk or posedge rst) begin
        bit pop, acc, fin;
        if (rst) begin
            m_q.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_left   = 0;
            m_irq    = 1'b1;
            m_div    = DIV_RST;
        end else begin
            pop = m_pop_now();
            acc = m_req_wr() && (m_off() == 4'h0) && m_ready();
            fin = 1'b0;
            if (m_active) begin
                if (m_left == 1) begin
                    if (m_pos == 9) begin
                        if (pop) m_start();
                        else begin
                            m_active = 1'b0;
                            fin      = 1'b1;
                        end
                    end else begin
                        m_pos++;
                        m_left = int'(m_div) + 1;
                    end
                end else begin
                    m_left--;
                end
            end else if (pop) begin
                m_start();
            end
            if (acc)
                m_q.push_back(bus.data_in[7:0]);
            if (acc)
                m_irq = 1'b0;
            else if (fin)
                m_irq = 1'b1;
            if (m_req_wr() && m_off() == 4'h8)
                m_div = (bus.data_in[15:0] < 16'd2) ? 16'd2 : bus.data_in[15:0];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("txd", uart_txd, m_active ? m_frame[m_pos] : 1'b1);
            check("irq", tx_empty_irq, m_irq);
            check("ready", bus.data_ready, m_ready());
            if (m_req_rd())
                check("rdata", bus.data_out, m_rdata());
        end
    end

    // ---------------- bus tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.sel          = 1'b0;
        bus.addr         = 4'h0;
        bus.data_write_n = 2'b11;
        bus.data_read_n  = 2'b11;
        bus.data_in      = 32'd0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d,
                             output int waited, output int acc_cyc);
        bus.sel          = 1'b1;
        bus.addr         = a;
        bus.data_write_n = 2'b00;
        bus.data_read_n  = 2'b11;
        bus.data_in      = d;
        waited           = 0;
        @(negedge clk);
        while (bus.data_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (bus.data_ready !== 1'b1) begin
            n_checks++;
            $display("FAIL write_timeout: data_ready=%b at offset 0x%0h, want 1", bus.data_ready, a);
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        bus_idle();
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d, output logic rdy);
        bus.sel          = 1'b1;
        bus.addr         = a;
        bus.data_read_n  = 2'b00;
        bus.data_write_n = 2'b11;
        @(negedge clk);
        d   = bus.data_out;
        rdy = bus.data_ready;
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int          w, a, a1, a6, cnt;
        logic [31:0] d;
        logic        r;
        logic [39:0] cap;

        bus_idle();
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", uart_txd, 1'b1);
        check("rst_irq", tx_empty_irq, 1'b1);
        check("rst_ready", bus.data_ready, 1'b0);
        check("rst_dout", bus.data_out, 32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;
        tick();

        bus_read(4'h4, d, r);
        check("status_idle", d, 32'h0000_0004);
        check("status_idle_rdy", r, 1'b1);
        bus_read(4'h8, d, r);
        check("div_reset", d, 32'h0000_022B);

        // single 0x55 frame at divisor 3: 40 clocks, start bit 1 clock after accept
        bus_write(4'h8, 32'd3, w, a);
        bus_read(4'h8, d, r);
        check("div_rb3", d, 32'd3);
        bus_write(4'h0, 32'h55, w, a);
        check("tx1_wait", w, 0);
        check("tx1_irq_low", tx_empty_irq, 1'b0);
        check("tx1_txd_accept", uart_txd, 1'b1);
        for (int i = 0; i < 40; i++) begin
            tick();
            cap[i] = uart_txd;
            if (i == 39) check("tx1_irq_lastbit", tx_empty_irq, 1'b0);
        end
        check("tx1_frame", cap, 40'hF0F0F0F0F0);
        tick();
        check("tx1_irq_back", tx_empty_irq, 1'b1);
        check("tx1_idle_txd", uart_txd, 1'b1);

        // five quick writes at divisor 2, then a sixth that must wait for a pop
        bus_write(4'h8, 32'd2, w, a);
        bus_write(4'h0, 32'hA1, w, a1);
        bus_write(4'h0, 32'h3C, w, a);
        bus_write(4'h0, 32'h0F, w, a);
        bus_write(4'h0, 32'hF0, w, a);
        bus_write(4'h0, 32'h96, w, a);
        check("fifo_5th_wait", w, 0);
        bus_read(4'h4, d, r);
        check("status_full", d, 32'h0000_0043);
        bus_write(4'h0, 32'h5A, w, a6);
        check("fifo_6th_stalled", (w > 0), 1'b1);
        check("fifo_6th_edge", a6 - a1, 31);
        while (cyc < a1 + 180) tick();
        check("b2b_irq_before", tx_empty_irq, 1'b0);
        tick();
        check("b2b_irq_after", tx_empty_irq, 1'b1);

        // divisor saturation
        bus_write(4'h8, 32'd0, w, a);
        bus_read(4'h8, d, r);
        check("div_sat0", d, 32'd2);
        bus_write(4'h8, 32'hABCD_0001, w, a);
        bus_read(4'h8, d, r);
        check("div_sat1", d, 32'd2);

        // unmapped offset
        bus_read(4'hC, d, r);
        check("unmapped_rd", d, 32'd0);
        check("unmapped_rdy", r, 1'b1);
        bus_write(4'hC, 32'hFFFF_FFFF, w, a);
        check("unmapped_wr_wait", w, 0);
        bus_read(4'h8, d, r);
        check("unmapped_div", d, 32'd2);
        bus_read(4'h4, d, r);
        check("unmapped_status", d, 32'h0000_0004);

        // reset during data bit 3
        bus_write(4'h8, 32'd3, w, a);
        bus_write(4'h0, 32'h55, w, a);
        while (cyc < a + 18) tick();
        check("mid_bit3_txd", uart_txd, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_txd", uart_txd, 1'b1);
        check("async_rst_irq", tx_empty_irq, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        bus_read(4'h4, d, r);
        check("post_rst_status", d, 32'h0000_0004);
        cnt = 0;
        repeat (60) begin
            tick();
            if (uart_txd !== 1'b1) cnt++;
        end
        check("post_rst_quiet", cnt, 0);

        // divisor change mid-bit: current bit keeps old length, next is 0x1235
        bus_write(4'h8, 32'd3, w, a);
        bus_write(4'h0, 32'h55, w, a);
        while (cyc < a + 14) tick();
        bus_write(4'h8, 32'h1234, w, a1);
        cnt = 0;
        while (uart_txd === 1'b1 && cnt < 10) begin
            cnt++;
            tick();
        end
        check("bit2_tail", cnt, 2);
        cnt = 0;
        while (uart_txd === 1'b0 && cnt < 6000) begin
            cnt++;
            tick();
        end
        check("bit3_len", cnt, 32'h1235);

        chk_en = 1'b0;
        rst    = 1'b1;
        tick();
        rst    = 1'b0;
        tick();
        chk_en = 1'b1;
        bus_read(4'h4, d, r);
        check("final_status", d, 32'h0000_0004);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
